cc_encoder: RTL
===============

# cc_encoder

Serialises MIDI Control Change requests into the MIDI byte stream for the outgoing UART transmitter. It is the transmit-side counterpart of the CC decoder path: synth-side logic presents (channel, CC number, CC value) with a valid/ready handshake. The block emits the status, number and value bytes to the transmitter over a byte-wide valid/ready interface. It optionally applies MIDI running status, with a timeout.

## Interface
- `RS_TIMEOUT`, default 32767: idle cycles after which running status is forgotten; 0 disables running status, so every message carries a status byte.
- `CNT_W`, default 15: idle counter width; must satisfy 2^CNT_W > RS_TIMEOUT.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cc_ch`  in  4  MIDI channel, 0–15.
- `cc_num`  in  7  controller number.
- `cc_val`  in  7  controller value.
- `cc_valid`  in  1  request valid.
- `cc_ready`  out  1  block can accept a request.
- `tx_data`  out  8  byte to transmitter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts byte.

## Operation
- FSM states: IDLE, STATUS, NUM, VAL.
- `cc_ready` is 1 only in IDLE. A request is captured on an edge where `cc_valid && cc_ready`; `cc_ch`, `cc_num` and `cc_val` are registered at that edge.
- Transition out of IDLE on capture:
  - Goes to NUM if running status applies.
  - Goes to STATUS otherwise.
- Running status applies when all of these hold at the capture edge:
  - `RS_TIMEOUT != 0`
  - `rs_vld == 1`
  - `rs_ch == cc_ch`
  - `idle_cnt < RS_TIMEOUT`
- Byte per state:
  - STATUS: `tx_data = {4'hB, ch}`.
  - NUM: `tx_data = {1'b0, num}`.
  - VAL: `tx_data = {1'b0, val}`.
- `tx_valid` is 1 in STATUS, NUM and VAL, and 0 in IDLE.
- A byte is accepted on an edge with `tx_valid && tx_ready`. Acceptance advances STATUS→NUM, NUM→VAL and VAL→IDLE. Without acceptance the state, `tx_data` and `tx_valid` hold unchanged.
- Acceptance in STATUS sets `rs_vld = 1` and `rs_ch = ch`.
- Idle counter `idle_cnt`:
  - Cleared to 0 on acceptance in VAL.
  - Increments by 1 on each cycle spent in IDLE while `idle_cnt < RS_TIMEOUT`.
  - Saturates at `RS_TIMEOUT`.
  - Holds in STATUS, NUM and VAL.
- `idle_cnt == RS_TIMEOUT` forces the next message to carry a status byte; `rs_vld` stays set but is ignored.
- Data bytes have MSB 0 by construction. No value range checks are needed.
- Input changes while not in IDLE are ignored.

## Timing
- Reset values, asynchronous:
  - state IDLE
  - `cc_ready = 1`
  - `tx_valid = 0`
  - `tx_data = 8'h00`
  - `rs_vld = 0`
  - `rs_ch = 0`
  - `idle_cnt = 0`
- Latency: capture at edge T puts the first byte on `tx_data` with `tx_valid = 1` from edge T.
- Each following byte appears the cycle after the previous one is accepted.
- Throughput with `tx_ready` tied to 1:
  - full message: 3 busy cycles (STATUS, NUM, VAL) plus 1 IDLE cycle, i.e. 4 cycles per message;
  - running-status message: 2 busy cycles plus 1 IDLE cycle, i.e. 3 cycles per message.
- The capture edge is not an IDLE cycle for counting purposes; `idle_cnt` does not increment on it.
- `cc_ready` falls the cycle after capture and rises the cycle after acceptance in VAL.
- `tx_valid` never drops without an acceptance, except on reset.
- Reset mid-message: outputs return to reset values immediately and the partial message is abandoned. The next message must carry a status byte because `rs_vld = 0`.
- Simultaneous `cc_valid` with acceptance in VAL: the request is not captured that edge (`cc_ready = 0`). It is captured on the following edge.

## Test plan
- Reset, then request ch=3, num=110, val=5 with `tx_ready = 1` → bytes 8'hB3, 8'h6E, 8'h05 on three consecutive cycles; `cc_ready` low for exactly 3 cycles.
- Second request within 10 cycles: ch=3, num=111, val=127 → bytes 8'h6F, 8'h7F only (no status byte).
- Same second request but on ch=4 → bytes 8'hB4, 8'h6F, 8'h7F.
- `RS_TIMEOUT = 8`: message on ch=0, 8 idle cycles, then a second ch=0 message → status 8'hB0 re-sent. With 7 idle cycles instead, the status byte is omitted.
- Backpressure: `tx_ready` low for 5 cycles during NUM → `tx_data = 8'h6E` and `tx_valid = 1` held stable; request inputs toggled meanwhile have no effect.
- Assert `rst` while in VAL → `tx_valid = 0` and `cc_ready = 1` immediately; the next ch=3 request emits 8'hB3 first.

Source files
------------

// File: rtl/cc_encoder.sv
// cc_encoder: serialises MIDI Control Change requests (channel, number, value)
// into a status/number/value byte stream for a UART transmitter, with optional
// running status that is forgotten after RS_TIMEOUT idle cycles.
module cc_encoder #(
  parameter int RS_TIMEOUT = 32767,
  parameter int CNT_W      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cc_ch,
  input  logic [6:0] cc_num,
  input  logic [6:0] cc_val,
  input  logic       cc_valid,
  output logic       cc_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STATUS = 2'd1,
    NUM    = 2'd2,
    VAL    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RS_LIM = CNT_W'(RS_TIMEOUT);

  state_t           state;
  logic [3:0]       ch_q;
  logic [6:0]       num_q;
  logic [6:0]       val_q;
  logic             rs_vld;
  logic [3:0]       rs_ch;
  logic [CNT_W-1:0] idle_cnt;

  logic capture;
  logic rs_apply;

  assign capture = cc_valid && cc_ready;

  // Status byte may be skipped only if the transmitter's last status is for
  // this channel and the line has not been idle long enough to forget it.
  assign rs_apply = (RS_TIMEOUT != 0) && rs_vld && (rs_ch == cc_ch) &&
                    (idle_cnt < RS_LIM);

  // Request fields are plain data: loaded on capture, never reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      ch_q  <= cc_ch;
      num_q <= cc_num;
      val_q <= cc_val;
    end
  end

  // Message sequencer with registered handshake outputs and running-status tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cc_ready <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      rs_vld   <= 1'b0;
      rs_ch    <= 4'h0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            // First byte is presented from the capture edge itself.
            cc_ready <= 1'b0;
            tx_valid <= 1'b1;
            if (rs_apply) begin
              state   <= NUM;
              tx_data <= {1'b0, cc_num};
            end else begin
              state   <= STATUS;
              tx_data <= {4'hB, cc_ch};
            end
          end else if (idle_cnt < RS_LIM) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        STATUS: begin
          if (tx_ready) begin
            rs_vld  <= 1'b1;
            rs_ch   <= ch_q;
            tx_data <= {1'b0, num_q};
            state   <= NUM;
          end
        end
        NUM: begin
          if (tx_ready) begin
            tx_data <= {1'b0, val_q};
            state   <= VAL;
          end
        end
        VAL: begin
          if (tx_ready) begin
            // Ready rises only after this edge, so a waiting request is
            // captured on the following edge.
            tx_valid <= 1'b0;
            cc_ready <= 1'b1;
            idle_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          cc_ready <= 1'b1;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
